gate_sweep: RTL and testbench

GATE_SWEEP -- requirements
Module: gate_sweep

---
 rtl/gate_pkg.sv | 17 +
 rtl/gate_reduce.sv | 27 ++
 rtl/gate_sweep.sv | 84 ++++++++
 tb/tb_gate_sweep.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared mode and FSM state encodings for gate blocks
package gate_pkg;

  // FSM state encodings for the sweep controller
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Gate function encodings; any other value is reserved and yields 0
  localparam int MODE_AND  = 0;
  localparam int MODE_OR   = 1;
  localparam int MODE_NAND = 2;
  localparam int MODE_NOR  = 3;
  localparam int MODE_XOR  = 4;
  localparam int MODE_XNOR = 5;

endpackage

// File: rtl/gate_reduce.sv
// rtl/gate_reduce.sv - combinational mode-selected reduction over an N-bit vector
import gate_pkg::*;

module gate_reduce #(
  parameter int N      = 2,
  parameter int MODE_W = 3
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [N-1:0]      vector,
  output logic              y
);

  // Select the reduction; reserved modes force 0
  always_comb begin
    y = 1'b0;
    case (mode)
      MODE_W'(MODE_AND):  y = &vector;
      MODE_W'(MODE_OR):   y = |vector;
      MODE_W'(MODE_NAND): y = ~&vector;
      MODE_W'(MODE_NOR):  y = ~|vector;
      MODE_W'(MODE_XOR):  y = ^vector;
      MODE_W'(MODE_XNOR): y = ~^vector;
      default:            y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep.sv
// rtl/gate_sweep.sv - walks every truth-table row of an N-input gate with backpressure
import gate_pkg::*;

module gate_sweep #(
  parameter int N      = 2,
  parameter int MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  input  logic              abort,
  input  logic              out_ready,
  output logic              row_valid,
  output logic [N-1:0]      row_in,
  output logic              row_out,
  output logic              busy,
  output logic              done,
  output logic [N:0]        ones_count
);

  // Index of the final row; the counter stops here instead of wrapping
  localparam logic [N:0] LAST_ROW = (N+1)'((1 << N) - 1);

  logic [1:0]        state;
  logic [N:0]        cnt;
  logic [MODE_W-1:0] mode_q;
  logic [N:0]        ones_q;

  // Result depends only on the latched mode and the row counter
  gate_reduce #(.N(N), .MODE_W(MODE_W)) u_reduce (
    .mode   (mode_q),
    .vector (cnt[N-1:0]),
    .y      (row_out)
  );

  // Sweep controller: abort takes priority over accepting the current row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_q <= '0;
      ones_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q <= mode;
            cnt    <= '0;
            ones_q <= '0;
            state  <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (out_ready) begin
            if (row_out) begin
              ones_q <= ones_q + (N+1)'(1);
            end
            if (cnt == LAST_ROW) begin
              state <= ST_DONE;
            end else begin
              cnt <= cnt + (N+1)'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign row_valid  = (state == ST_SWEEP);
  assign busy       = (state == ST_SWEEP);
  assign done       = (state == ST_DONE);
  assign row_in     = cnt[N-1:0];
  assign ones_count = ones_q;

endmodule

// File: tb/tb_gate_sweep.sv
// tb/tb_gate_sweep.sv - directed-vector bench for gate_sweep at several widths
module tb_gate_sweep;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vec  = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  // Instance a: N=2
  logic start_a = 0, abort_a = 0, rdy_a = 0;
  logic [2:0] mode_a = 0;
  logic vld_a, rout_a, busy_a, done_a;
  logic [1:0] rin_a;
  logic [2:0] ones_a;
  gate_sweep #(.N(2), .MODE_W(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .abort(abort_a),
    .out_ready(rdy_a), .row_valid(vld_a), .row_in(rin_a), .row_out(rout_a),
    .busy(busy_a), .done(done_a), .ones_count(ones_a));

  // Instance b: N=3
  logic start_b = 0, abort_b = 0, rdy_b = 0;
  logic [2:0] mode_b = 0;
  logic vld_b, rout_b, busy_b, done_b;
  logic [2:0] rin_b;
  logic [3:0] ones_b;
  gate_sweep #(.N(3), .MODE_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .abort(abort_b),
    .out_ready(rdy_b), .row_valid(vld_b), .row_in(rin_b), .row_out(rout_b),
    .busy(busy_b), .done(done_b), .ones_count(ones_b));

  // Instance c: N=4
  logic start_c = 0, abort_c = 0, rdy_c = 0;
  logic [2:0] mode_c = 0;
  logic vld_c, rout_c, busy_c, done_c;
  logic [3:0] rin_c;
  logic [4:0] ones_c;
  gate_sweep #(.N(4), .MODE_W(3)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .abort(abort_c),
    .out_ready(rdy_c), .row_valid(vld_c), .row_in(rin_c), .row_out(rout_c),
    .busy(busy_c), .done(done_c), .ones_count(ones_c));

  // Instance d: N=1
  logic start_d = 0, abort_d = 0, rdy_d = 0;
  logic [2:0] mode_d = 0;
  logic vld_d, rout_d, busy_d, done_d;
  logic [0:0] rin_d;
  logic [1:0] ones_d;
  gate_sweep #(.N(1), .MODE_W(3)) dut_d (
    .clk(clk), .rst(rst), .start(start_d), .mode(mode_d), .abort(abort_d),
    .out_ready(rdy_d), .row_valid(vld_d), .row_in(rin_d), .row_out(rout_d),
    .busy(busy_d), .done(done_d), .ones_count(ones_d));

  // Instance e: N=8
  logic start_e = 0, abort_e = 0, rdy_e = 0;
  logic [2:0] mode_e = 0;
  logic vld_e, rout_e, busy_e, done_e;
  logic [7:0] rin_e;
  logic [8:0] ones_e;
  gate_sweep #(.N(8), .MODE_W(3)) dut_e (
    .clk(clk), .rst(rst), .start(start_e), .mode(mode_e), .abort(abort_e),
    .out_ready(rdy_e), .row_valid(vld_e), .row_in(rin_e), .row_out(rout_e),
    .busy(busy_e), .done(done_e), .ones_count(ones_e));

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vec++; if (vld_a !== 1'b0) begin errs++; $display("FAIL reset_valid_a got %b exp 0", vld_a); end
    vec++; if (busy_b !== 1'b0) begin errs++; $display("FAIL reset_busy_b got %b exp 0", busy_b); end
    vec++; if (done_c !== 1'b0) begin errs++; $display("FAIL reset_done_c got %b exp 0", done_c); end
    vec++; if (ones_e !== 9'd0) begin errs++; $display("FAIL reset_ones_e got %0d exp 0", ones_e); end
    vec++; if (rin_c !== 4'd0) begin errs++; $display("FAIL reset_row_in_c got %0d exp 0", rin_c); end
    rst = 1'b0;
    @(negedge clk);
    vec++; if (busy_a !== 1'b0) begin errs++; $display("FAIL post_reset_busy_a got %b exp 0", busy_a); end
  endtask

  task automatic test_nor_n2();
    logic [3:0] exp_out;
    exp_out = 4'b0001;  // bit r = NOR of row r: only row 00 is 1
    start_a = 1; mode_a = 3'd3; rdy_a = 1;
    @(negedge clk);
    start_a = 0; mode_a = 3'd0;  // mid-sweep mode change must not matter
    for (int r = 0; r < 4; r++) begin
      vec++; if (vld_a !== 1'b1) begin errs++; $display("FAIL nor_valid r=%0d got %b exp 1", r, vld_a); end
      vec++; if (rin_a !== 2'(r)) begin errs++; $display("FAIL nor_row_in got %0d exp %0d", rin_a, r); end
      vec++; if (rout_a !== exp_out[r]) begin errs++; $display("FAIL nor_row_out r=%0d got %b exp %b", r, rout_a, exp_out[r]); end
      vec++; if (done_a !== 1'b0) begin errs++; $display("FAIL nor_early_done r=%0d got %b exp 0", r, done_a); end
      @(negedge clk);
    end
    vec++; if (done_a !== 1'b1) begin errs++; $display("FAIL nor_done got %b exp 1", done_a); end
    vec++; if (vld_a !== 1'b0) begin errs++; $display("FAIL nor_valid_in_done got %b exp 0", vld_a); end
    vec++; if (ones_a !== 3'd1) begin errs++; $display("FAIL nor_ones got %0d exp 1", ones_a); end
    @(negedge clk);
    vec++; if (done_a !== 1'b0) begin errs++; $display("FAIL nor_done_pulse got %b exp 0", done_a); end
    vec++; if (busy_a !== 1'b0) begin errs++; $display("FAIL nor_idle_busy got %b exp 0", busy_a); end
    @(negedge clk);
    vec++; if (ones_a !== 3'd1) begin errs++; $display("FAIL nor_ones_hold got %0d exp 1", ones_a); end
  endtask

  task automatic test_xor_n3();
    logic [7:0] exp_out;
    int exp_r;
    exp_out = 8'b1001_0110;  // bit r = parity of r
    exp_r = 0;
    start_b = 1; mode_b = 3'd4; rdy_b = 0;
    @(negedge clk);
    start_b = 0;
    for (int k = 0; k < 16; k++) begin
      vec++; if (vld_b !== 1'b1) begin errs++; $display("FAIL xor_valid k=%0d got %b exp 1", k, vld_b); end
      vec++; if (rin_b !== 3'(exp_r)) begin errs++; $display("FAIL xor_row_in k=%0d got %0d exp %0d", k, rin_b, exp_r); end
      vec++; if (rout_b !== exp_out[exp_r]) begin errs++; $display("FAIL xor_row_out k=%0d got %b exp %b", k, rout_b, exp_out[exp_r]); end
      vec++; if (done_b !== 1'b0) begin errs++; $display("FAIL xor_early_done k=%0d got %b exp 0", k, done_b); end
      rdy_b = (k % 2 == 1);
      @(negedge clk);
      if (rdy_b) exp_r++;
    end
    rdy_b = 0;
    vec++; if (done_b !== 1'b1) begin errs++; $display("FAIL xor_done got %b exp 1", done_b); end
    vec++; if (ones_b !== 4'd4) begin errs++; $display("FAIL xor_ones got %0d exp 4", ones_b); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++; if (done_b !== 1'b0) begin errs++; $display("FAIL xor_second_done k=%0d got %b exp 0", k, done_b); end
    end
  endtask

  task automatic test_abort_n2();
    start_a = 1; mode_a = 3'd0; rdy_a = 1;
    @(negedge clk);
    start_a = 0;
    for (int r = 0; r < 3; r++) begin
      vec++; if (rout_a !== 1'b0) begin errs++; $display("FAIL and_row_out r=%0d got %b exp 0", r, rout_a); end
      @(negedge clk);
    end
    vec++; if (rin_a !== 2'd3) begin errs++; $display("FAIL and_last_row got %0d exp 3", rin_a); end
    vec++; if (rout_a !== 1'b1) begin errs++; $display("FAIL and_last_out got %b exp 1", rout_a); end
    abort_a = 1;
    @(negedge clk);
    abort_a = 0;
    vec++; if (done_a !== 1'b0) begin errs++; $display("FAIL abort_done got %b exp 0", done_a); end
    vec++; if (busy_a !== 1'b0) begin errs++; $display("FAIL abort_busy got %b exp 0", busy_a); end
    vec++; if (vld_a !== 1'b0) begin errs++; $display("FAIL abort_valid got %b exp 0", vld_a); end
    vec++; if (ones_a !== 3'd0) begin errs++; $display("FAIL abort_ones got %0d exp 0", ones_a); end
    @(negedge clk);
    vec++; if (done_a !== 1'b0) begin errs++; $display("FAIL abort_late_done got %b exp 0", done_a); end
  endtask

  task automatic test_reset_mid_n4();
    start_c = 1; mode_c = 3'd2; rdy_c = 1;
    @(negedge clk);
    start_c = 0;
    for (int r = 0; r < 5; r++) @(negedge clk);
    vec++; if (rin_c !== 4'b0101) begin errs++; $display("FAIL nand_pre_rst_row got %0d exp 5", rin_c); end
    vec++; if (ones_c !== 5'd5) begin errs++; $display("FAIL nand_pre_rst_ones got %0d exp 5", ones_c); end
    rst = 1;
    #1;
    vec++; if (vld_c !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", vld_c); end
    vec++; if (busy_c !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", busy_c); end
    vec++; if (rin_c !== 4'd0) begin errs++; $display("FAIL rst_row_in got %0d exp 0", rin_c); end
    vec++; if (ones_c !== 5'd0) begin errs++; $display("FAIL rst_ones got %0d exp 0", ones_c); end
    vec++; if (rout_c !== 1'b0) begin errs++; $display("FAIL rst_row_out (mode 0 AND of 0) got %b exp 0", rout_c); end
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vec++; if (done_c !== 1'b0 || busy_c !== 1'b0) begin errs++; $display("FAIL rst_release got done=%b busy=%b exp 0 0", done_c, busy_c); end
    end
    start_c = 1;
    @(negedge clk);
    start_c = 0;
    for (int r = 0; r < 16; r++) begin
      vec++; if (rin_c !== 4'(r)) begin errs++; $display("FAIL nand_row_in got %0d exp %0d", rin_c, r); end
      vec++; if (rout_c !== (r != 15)) begin errs++; $display("FAIL nand_row_out r=%0d got %b exp %b", r, rout_c, (r != 15)); end
      @(negedge clk);
    end
    vec++; if (done_c !== 1'b1) begin errs++; $display("FAIL nand_done got %b exp 1", done_c); end
    vec++; if (ones_c !== 5'd15) begin errs++; $display("FAIL nand_ones got %0d exp 15", ones_c); end
    @(negedge clk);
  endtask

  task automatic test_reserved_n1();
    start_d = 1; mode_d = 3'd6; rdy_d = 1;
    @(negedge clk);
    // keep start high through the sweep and DONE; it must be ignored there
    for (int r = 0; r < 2; r++) begin
      vec++; if (rin_d !== 1'(r)) begin errs++; $display("FAIL rsv_row_in got %0d exp %0d", rin_d, r); end
      vec++; if (rout_d !== 1'b0) begin errs++; $display("FAIL rsv_row_out r=%0d got %b exp 0", r, rout_d); end
      @(negedge clk);
    end
    vec++; if (done_d !== 1'b1) begin errs++; $display("FAIL rsv_done got %b exp 1", done_d); end
    vec++; if (ones_d !== 2'd0) begin errs++; $display("FAIL rsv_ones got %0d exp 0", ones_d); end
    @(negedge clk);
    start_d = 0;
    vec++; if (busy_d !== 1'b0) begin errs++; $display("FAIL rsv_restart got busy=%b exp 0", busy_d); end
    @(negedge clk);
    vec++; if (vld_d !== 1'b0) begin errs++; $display("FAIL rsv_idle_valid got %b exp 0", vld_d); end
  endtask

  task automatic test_or_n8();
    start_e = 1; mode_e = 3'd1; rdy_e = 1;
    @(negedge clk);
    start_e = 0;
    for (int k = 1; k <= 256; k++) begin
      vec++; if (vld_e !== 1'b1 || rin_e !== 8'(k - 1)) begin errs++; $display("FAIL or_row cycle=%0d got valid=%b row=%0d exp 1 %0d", k, vld_e, rin_e, k - 1); end
      vec++; if (rout_e !== (k != 1)) begin errs++; $display("FAIL or_row_out cycle=%0d got %b exp %b", k, rout_e, (k != 1)); end
      @(negedge clk);
    end
    vec++; if (done_e !== 1'b1) begin errs++; $display("FAIL or_done_cycle257 got %b exp 1", done_e); end
    vec++; if (ones_e !== 9'd255) begin errs++; $display("FAIL or_ones got %0d exp 255", ones_e); end
    @(negedge clk);
    vec++; if (done_e !== 1'b0) begin errs++; $display("FAIL or_done_pulse got %b exp 0", done_e); end
  endtask

  initial begin
    test_reset();
    test_nor_n2();
    test_xor_n3();
    test_abort_n2();
    test_reset_mid_n4();
    test_reserved_n1();
    test_or_n8();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
